// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC conversion scheduler
// Purpose: FSM state encoding, frame field widths and the command bit pattern
//          sent to the serial converter (start, single-ended, channel, MSB-first).
// Ports:   none (package)
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    NULLB,
    DATA,
    DONE,
    GAP
  } state_e;

  localparam int CMD_BITS  = 4;
  localparam int DATA_BITS = 8;

  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  // Command bit idx (0 = first on the wire) for channel ch.
  function automatic logic cmd_bit(input logic [1:0] idx, input logic ch);
    case (idx)
      2'd0:    return CMD_START;
      2'd1:    return CMD_SGL;
      2'd2:    return ch;
      default: return CMD_MSBF;
    endcase
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - sclk half-period timer for the ADC serial link
// Purpose: while en is high, divides clk into sclk half-periods of CLK_DIV
//          cycles, always starting with a low half; idles low with the
//          counter cleared whenever en is low.
// Ports:   clk, rstc_n - clock, synchronous active-low reset
//          en          - run the divider
//          sclk        - registered serial clock
//          rise_tick   - high in the clk cycle whose edge drives sclk 0->1
//          fall_tick   - high in the clk cycle whose edge drives sclk 1->0
module adc_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstc_n,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  logic [7:0] cnt_q, cnt_d;
  logic       ph_q, ph_d;
  logic       half_end;

  assign half_end = (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d = 8'd0;
    ph_d  = 1'b0;
    if (en) begin
      cnt_d = half_end ? 8'd0 : cnt_q + 8'd1;
      ph_d  = half_end ? ~ph_q : ph_q;
    end
  end

  assign sclk      = ph_q;
  assign rise_tick = en & half_end & ~ph_q;
  assign fall_tick = en & half_end & ph_q;

  always_ff @(posedge clk) begin
    if (!rstc_n) begin
      cnt_q <= 8'd0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/adc_conv_sched.sv
// rtl/adc_conv_sched.sv - two-channel serial ADC conversion scheduler
// Purpose: collects per-channel requests (manual and periodic), arbitrates
//          round-robin, runs one 13-sclk converter frame per grant, publishes
//          the 8-bit result with a one-cycle strobe and tracks a per-channel
//          over-threshold alarm with clear hysteresis.
// Ports:   clk, rstc_n                 - clock, synchronous active-low reset
//          req[1:0], auto_en           - manual requests, periodic enable
//          thresh[7:0]                 - alarm threshold (both channels)
//          adc_cs_n/adc_sclk/adc_din   - converter chip-select, clock, command
//          adc_dout                    - converter data
//          res_data/res_chan/res_valid - result, its channel, strobe
//          busy, alarm[1:0]            - frame in progress, alarm flags
module adc_conv_sched
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int HYST          = 2
) (
  input  logic       clk,
  input  logic       rstc_n,
  input  logic [1:0] req,
  input  logic       auto_en,
  input  logic [7:0] thresh,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_din,
  input  logic       adc_dout,
  output logic [7:0] res_data,
  output logic       res_chan,
  output logic       res_valid,
  output logic       busy,
  output logic [1:0] alarm
);

  localparam int SW = $clog2(SAMPLE_PERIOD + 1);

  state_e        state_q, state_d;
  logic [8:0]    timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          ch_q, ch_d;
  logic          last_q, last_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    res_data_q, res_data_d;
  logic          res_chan_q, res_chan_d;
  logic          res_valid_q, res_valid_d;
  logic          cs_n_q, cs_n_d;
  logic          din_q, din_d;
  logic          busy_q, busy_d;
  logic [1:0]    alarm_q, alarm_d;
  logic [1:0]    pending_q, pending_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [1:0]    clr;
  logic          auto_set;
  logic [8:0]    thresh_lo;
  logic          sclk_en, rise_tick, fall_tick;

  assign sclk_en = (state_q == CMD) || (state_q == NULLB) || (state_q == DATA);

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rstc_n    (rstc_n),
    .en        (sclk_en),
    .sclk      (adc_sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Periodic round trigger: counter only runs while auto_en is high.
  assign auto_set = auto_en && (samp_q == SW'(SAMPLE_PERIOD - 1));
  assign samp_d   = (!auto_en || auto_set) ? '0 : samp_q + SW'(1);

  // Alarm clear level, saturating at zero.
  assign thresh_lo = ({1'b0, thresh} > 9'(HYST)) ? ({1'b0, thresh} - 9'(HYST)) : 9'd0;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    ch_d        = ch_q;
    last_d      = last_q;
    shift_d     = shift_q;
    res_data_d  = res_data_q;
    res_chan_d  = res_chan_q;
    res_valid_d = 1'b0;
    cs_n_d      = cs_n_q;
    din_d       = din_q;
    alarm_d     = alarm_q;
    clr         = 2'b00;

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          // Tie goes to the channel not served last time.
          ch_d    = (pending_q == 2'b11) ? ~last_q : pending_q[1];
          last_d  = ch_d;
          clr     = ch_d ? 2'b10 : 2'b01;
          cs_n_d  = 1'b0;
          timer_d = 9'(CLK_DIV - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (timer_q == 9'd0) begin
          bit_cnt_d = 3'd0;
          din_d     = cmd_bit(2'd0, ch_q);
          state_d   = CMD;
        end else begin
          timer_d = timer_q - 9'd1;
        end
      end
      CMD: begin
        if (fall_tick) begin
          if (bit_cnt_q == 3'(CMD_BITS - 1)) begin
            din_d   = 1'b0;
            state_d = NULLB;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            din_d     = cmd_bit(2'(bit_cnt_q + 3'd1), ch_q);
          end
        end
      end
      NULLB: begin
        // The null-bit sample is not captured.
        if (fall_tick) begin
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (rise_tick) begin
          shift_d = {shift_q[6:0], adc_dout};
        end
        if (fall_tick) begin
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            // Results become visible during the DONE cycle.
            cs_n_d      = 1'b1;
            res_data_d  = shift_q;
            res_chan_d  = ch_q;
            res_valid_d = 1'b1;
            if (shift_q > thresh) begin
              alarm_d[ch_q] = 1'b1;
            end else if ({1'b0, shift_q} < thresh_lo) begin
              alarm_d[ch_q] = 1'b0;
            end
            state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        timer_d = 9'(2 * CLK_DIV - 1);
        state_d = GAP;
      end
      GAP: begin
        if (timer_q == 9'd0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 9'd1;
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // A request arriving on the grant cycle re-arms the flag being cleared.
  assign pending_d = (pending_q & ~clr) | req | {2{auto_set}};

  always_ff @(posedge clk) begin
    if (!rstc_n) begin
      state_q     <= IDLE;
      timer_q     <= 9'd0;
      bit_cnt_q   <= 3'd0;
      ch_q        <= 1'b0;
      last_q      <= 1'b1;
      shift_q     <= 8'd0;
      res_data_q  <= 8'd0;
      res_chan_q  <= 1'b0;
      res_valid_q <= 1'b0;
      cs_n_q      <= 1'b1;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      alarm_q     <= 2'b00;
      pending_q   <= 2'b00;
      samp_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_q        <= ch_d;
      last_q      <= last_d;
      shift_q     <= shift_d;
      res_data_q  <= res_data_d;
      res_chan_q  <= res_chan_d;
      res_valid_q <= res_valid_d;
      cs_n_q      <= cs_n_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      alarm_q     <= alarm_d;
      pending_q   <= pending_d;
      samp_q      <= samp_d;
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_din   = din_q;
  assign res_data  = res_data_q;
  assign res_chan  = res_chan_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_adc_conv_sched.sv
// tb/tb_adc_conv_sched.sv - self-checking bench for adc_conv_sched
module tb_adc_conv_sched;

  localparam int CD = 4;
  localparam int SP = 300;
  localparam int HY = 2;

  logic       clk = 1'b0;
  logic       rstc_n;
  logic [1:0] req;
  logic       auto_en;
  logic [7:0] thresh;
  logic       adc_cs_n, adc_sclk, adc_din, adc_dout;
  logic [7:0] res_data;
  logic       res_chan, res_valid, busy;
  logic [1:0] alarm;

  adc_conv_sched #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .HYST(HY)) dut (
    .clk       (clk),
    .rstc_n    (rstc_n),
    .req       (req),
    .auto_en   (auto_en),
    .thresh    (thresh),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .adc_din   (adc_din),
    .adc_dout  (adc_dout),
    .res_data  (res_data),
    .res_chan  (res_chan),
    .res_valid (res_valid),
    .busy      (busy),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model and converter model state
  logic [1:0] pend_m;
  logic       last_m;
  int         acnt;
  logic       prev_cs, prev_sclk, prev_valid;
  int         low_cnt, high_cnt, mon_rises;
  logic       seen_end, cur_ch, alarm_chk;
  logic [3:0] dinv, last_din;
  logic [7:0] cur_val, held_data;
  logic       held_chan;
  logic [1:0] alarm_m;
  int         last_low, n_results, n_starts, lo;
  logic [8:0] e;
  logic [8:0] exp_q[$];
  logic [7:0] val_q[$];
  logic [8:0] got_q[$];

  initial begin
    n_results = 0;
    n_starts  = 0;
  end

  always @(negedge clk) begin
    if (!rstc_n) begin
      pend_m = 2'b00; last_m = 1'b1; acnt = 0;
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_valid = 1'b0;
      low_cnt = 0; high_cnt = 0; mon_rises = 0; seen_end = 1'b0;
      exp_q.delete(); held_data = 8'd0; held_chan = 1'b0;
      alarm_m = 2'b00; alarm_chk = 1'b0; adc_dout = 1'b0;
    end else begin
      if (alarm_chk) begin
        check("alarm", alarm, alarm_m);
        alarm_chk = 1'b0;
      end
      // Frame start: decide which channel the rules say must be served.
      if (prev_cs && !adc_cs_n) begin
        check("start_pend", |pend_m, 1);
        if (seen_end) check("gap_min", high_cnt >= 2 * CD + 1, 1);
        if (pend_m == 2'b11) cur_ch = !last_m;
        else                 cur_ch = (pend_m == 2'b10);
        last_m = cur_ch;
        pend_m[cur_ch] = 1'b0;
        cur_val = (val_q.size() > 0) ? val_q.pop_front() : 8'($urandom_range(0, 255));
        exp_q.push_back({cur_ch, cur_val});
        n_starts++;
        mon_rises = 0; low_cnt = 0; dinv = 4'd0; adc_dout = 1'b0;
      end
      if (!adc_cs_n) begin
        low_cnt++;
        check("busy_in_frame", busy, 1);
        if (adc_sclk && !prev_sclk) begin
          mon_rises++;
          if (mon_rises <= 4) dinv = {dinv[2:0], adc_din};
          else check("din_zero", adc_din, 0);
          if (mon_rises >= 5 && mon_rises <= 12) adc_dout = cur_val[12 - mon_rises];
          else adc_dout = 1'b0;
        end
      end
      if (!prev_cs && adc_cs_n) begin
        check("cs_low_len", low_cnt, 27 * CD);
        check("sclk_periods", mon_rises, 13);
        check("din_cmd", dinv, {1'b1, 1'b1, cur_ch, 1'b1});
        last_low = low_cnt; last_din = dinv;
        seen_end = 1'b1; high_cnt = 0;
      end
      if (adc_cs_n) begin
        high_cnt++;
        check("sclk_idle", adc_sclk, 0);
      end
      if (prev_valid) check("valid_one_cycle", res_valid, 0);
      if (res_valid) begin
        check("res_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("res_chan", res_chan, e[8]);
          check("res_data", res_data, e[7:0]);
          lo = int'(thresh) - HY;
          if (lo < 0) lo = 0;
          if (int'(e[7:0]) > int'(thresh)) alarm_m[e[8]] = 1'b1;
          else if (int'(e[7:0]) < lo)      alarm_m[e[8]] = 1'b0;
        end
        held_data = res_data; held_chan = res_chan;
        got_q.push_back({res_chan, res_data});
        n_results++;
        alarm_chk = 1'b1;
      end else begin
        check("hold_data", res_data, held_data);
        check("hold_chan", res_chan, held_chan);
      end
      pend_m = pend_m | req;
      if (auto_en) begin
        acnt++;
        if (acnt == SP) begin
          pend_m = 2'b11;
          acnt = 0;
        end
      end else begin
        acnt = 0;
      end
    end
    prev_cs    = adc_cs_n;
    prev_sclk  = adc_sclk;
    prev_valid = res_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_results(input string tag, input int target, input int budget);
    int n = 0;
    while (n_results < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, n_results, target);
  endtask

  task automatic do_reset();
    rstc_n = 1'b0;
    tick(2);
    rstc_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int         r0, s0, guard, n;
    logic [8:0] g0, g1;
    logic [7:0] t3_val[5] = '{8'd8, 8'd6, 8'd4, 8'd2, 8'd0};
    logic [7:0] t3_thr[5] = '{8'd7, 8'd7, 8'd7, 8'd1, 8'd1};
    logic       t3_exp[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rstc_n = 1'b0; req = 2'b00; auto_en = 1'b0; thresh = 8'hFF;
    tick(3);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_din", adc_din, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_chan", res_chan, 0);
    check("rst_busy", busy, 0);
    check("rst_alarm", alarm, 0);
    rstc_n = 1'b1;
    tick(5);
    check("idle_no_frame", adc_cs_n, 1);

    // Single ch0 conversion returning 0x5A
    r0 = n_results;
    val_q.push_back(8'h5A);
    req = 2'b01; tick(1); req = 2'b00;
    wait_results("t1_done", r0 + 1, 400);
    g0 = got_q[$];
    check("t1_data", g0[7:0], 8'h5A);
    check("t1_chan", g0[8], 0);
    check("t1_cs_low", last_low, 108);
    check("t1_din", last_din, 4'b1101);

    // Simultaneous requests after reset: ch0 then ch1
    do_reset();
    r0 = n_results;
    val_q.push_back(8'h11);
    val_q.push_back(8'h22);
    req = 2'b11; tick(1); req = 2'b00;
    wait_results("t2_done", r0 + 2, 600);
    g0 = got_q[$ - 1];
    g1 = got_q[$];
    check("t2_first_chan", g0[8], 0);
    check("t2_second_chan", g1[8], 1);
    check("t2_second_data", g1[7:0], 8'h22);

    // Alarm hysteresis on ch1, including the saturated clear level
    for (int i = 0; i < 5; i++) begin
      thresh = t3_thr[i];
      r0 = n_results;
      val_q.push_back(t3_val[i]);
      req = 2'b10; tick(1); req = 2'b00;
      wait_results("t3_done", r0 + 1, 400);
      tick(2);
      check("t3_alarm1", alarm[1], t3_exp[i]);
    end
    thresh = 8'hFF;

    // Re-request of ch0 while it is being converted
    r0 = n_results;
    req = 2'b01; tick(1); req = 2'b00;
    guard = 0;
    while (adc_cs_n && guard < 50) begin tick(1); guard++; end
    check("t4_started", adc_cs_n, 0);
    tick(30);
    req = 2'b01; tick(1); req = 2'b00;
    wait_results("t4_done", r0 + 2, 700);
    g0 = got_q[$ - 1];
    g1 = got_q[$];
    check("t4_first_chan", g0[8], 0);
    check("t4_second_chan", g1[8], 0);

    // Reset in the middle of DATA bit 3 aborts the frame
    r0 = n_results;
    req = 2'b01; tick(1); req = 2'b00;
    guard = 0;
    while (!(mon_rises == 9 && !adc_cs_n) && guard < 400) begin tick(1); guard++; end
    check("t5_reach_data3", guard < 400, 1);
    rstc_n = 1'b0;
    tick(1);
    check("t5_cs_n", adc_cs_n, 1);
    check("t5_busy", busy, 0);
    check("t5_valid", res_valid, 0);
    rstc_n = 1'b1;
    s0 = n_starts;
    tick(300);
    check("t5_no_result", n_results, r0);
    check("t5_no_restart", n_starts, s0);

    // Randomized request traffic against the reference model
    thresh = 8'($urandom_range(0, 255));
    repeat (3000) begin
      req = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick(1);
    end
    req = 2'b00;
    tick(2);
    guard = 0;
    while (!(exp_q.size() == 0 && pend_m == 2'b00 && !busy) && guard < 3000) begin
      tick(1);
      guard++;
    end
    check("t6_drain", guard < 3000, 1);
    tick(20);
    check("t6_quiet", adc_cs_n, 1);

    // Periodic rounds: three rounds, one conversion per channel each
    r0 = n_results;
    auto_en = 1'b1;
    tick(950);
    auto_en = 1'b0;
    wait_results("t7_done", r0 + 6, 600);
    tick(400);
    check("t7_count", n_results, r0 + 6);
    n = got_q.size();
    for (int i = 1; i < 6; i++) begin
      g0 = got_q[n - i];
      g1 = got_q[n - i - 1];
      check("t7_alternate", g0[8] ^ g1[8], 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_conv_sched.md
ADC_CONV_SCHED -- requirements
Module: adc_conv_sched

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per sclk half-period (legal 2..255).
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 1000, clk cycles between automatic conversion rounds.
REQ-003 SHALL have parameter HYST, default 2, alarm clear hysteresis in LSBs.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rstc_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req  input  2  per-channel conversion request, one bit per channel, sampled each clk.
REQ-007 SHALL have port auto_en  input  1  enables periodic conversion of both channels.
REQ-008 SHALL have port thresh  input  8  alarm threshold, shared by both channels.
REQ-009 SHALL have ports adc_cs_n, adc_sclk and adc_din  output  1 each  serial converter chip-select (active-low), clock and command line.
REQ-010 SHALL have port adc_dout  input  1  serial converter data line.
REQ-011 SHALL have ports res_data  output  8, res_chan  output  1, res_valid  output  1  conversion result, its channel, and a one-cycle result strobe.
REQ-012 SHALL have ports busy  output  1 and alarm  output  2  conversion in progress, and per-channel over-threshold flag.

Function
REQ-013 SHALL latch each req bit into a sticky pending[ch] flag; pending[ch] clears only when ch is granted; a req for the channel being converted re-sets its pending flag.
REQ-014 SHALL, when auto_en=1, run a free-running counter that sets both pending flags every SAMPLE_PERIOD cycles; counter holds at 0 while auto_en=0.
REQ-015 SHALL use FSM states IDLE, SETUP, CMD, NULLB, DATA, DONE, GAP; IDLE->SETUP when any pending, else stay.
REQ-016 SHALL arbitrate round-robin: both pending -> grant channel not last served; one pending -> grant it; after reset, channel 0 wins first tie.
REQ-017 SHALL drive adc_cs_n low from SETUP entry through last DATA bit; SETUP lasts CLK_DIV cycles with adc_sclk=0.
REQ-018 SHALL generate 13 sclk periods (4 CMD, 1 NULLB, 8 DATA), each CLK_DIV cycles low then CLK_DIV cycles high; total cs_n-low time 27*CLK_DIV cycles.
REQ-019 SHALL update adc_din at start of each sclk low half: CMD bits in order 1 (start), 1 (single-ended), ch, 1 (MSB-first); adc_din=0 in NULLB and DATA.
REQ-020 SHALL sample adc_dout on the clk edge that drives adc_sclk 0->1, during DATA only, shifting MSB first into an 8-bit register; NULLB sample discarded.
REQ-021 SHALL in DONE (one cycle) raise adc_cs_n, load res_data/res_chan, pulse res_valid=1 for exactly one cycle, then enter GAP.
REQ-022 SHALL hold adc_cs_n high in GAP for 2*CLK_DIV cycles, then return to IDLE; a new grant is not possible before GAP completes.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL in DONE update alarm[ch]: set if result > thresh; clear if result < thresh-HYST (thresh-HYST saturating at 0); otherwise hold.
REQ-025 SHALL keep res_data/res_chan stable between res_valid pulses.

Reset
REQ-026 SHALL, with rstc_n=0 at a clk edge, force FSM=IDLE, adc_cs_n=1, adc_sclk=0, adc_din=0, res_valid=0, res_data=0, res_chan=0, busy=0, alarm=0, pending=0, sample counter=0, round-robin pointer favouring channel 0.
REQ-027 SHALL abort any in-progress conversion on reset with no res_valid pulse; adc_cs_n high on the first cycle after the reset edge.

Structure
REQ-028 SHALL place FSM state enum, CMD_BITS=4, DATA_BITS=8, and command bit constants in shared package adc_pkg.
REQ-029 SHALL implement sclk half-period timing in sub-module adc_sclk_gen (enable, CLK_DIV counter, rise/fall tick outputs).

Verification
REQ-030 SHALL cover: CLK_DIV=4, req=01 once, model returns 0x5A -> adc_din pattern 1,1,0,1; cs_n low 108 cycles; res_valid one cycle, res_data=0x5A, res_chan=0.
REQ-031 SHALL cover: req=11 same cycle -> ch0 converted first, then ch1 after GAP of 8 cycles; two res_valid pulses, res_chan 0 then 1.
REQ-032 SHALL cover: thresh=7, HYST=2, results 8,6,4 on ch1 -> alarm[1]=1,1,0 after each DONE.
REQ-033 SHALL cover: auto_en=1, SAMPLE_PERIOD=300 -> each 300-cycle round yields one conversion per channel, alternating, no loss.
REQ-034 SHALL cover: rstc_n=0 held one cycle during DATA bit 3 -> next cycle adc_cs_n=1, busy=0, no res_valid, pending=00.
REQ-035 SHALL cover: req[0] pulsed while ch0 converting -> ch0 converted again after GAP.
